// File: rtl/aexm_dwb_slave.sv
// Data-bus target for the AEXM core: registered scratchpad with byte-lane
// writes, a fixed number of wait states and a single-cycle ack/err pulse.
module aexm_dwb_slave #(
  parameter int AW  = 4,
  parameter int LAT = 1
) (
  input  logic          gclk,
  input  logic          grst_n,
  input  logic          dwb_stb_i,
  input  logic          dwb_we_i,
  input  logic [AW-1:0] dwb_adr_i,
  input  logic [3:0]    dwb_sel_i,
  input  logic [31:0]   dwb_dat_i,
  output logic [31:0]   dwb_dat_o,
  output logic          dwb_ack_o,
  output logic          dwb_err_o,
  output logic          busy_o
);

  // state | meaning
  // IDLE  | waiting for dwb_stb_i; request is captured on the strobe edge
  // WAIT  | counting wait states down; a dropped strobe aborts
  // RESP  | ack/err pulse cycle; always returns to IDLE
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } stateT;

  localparam logic [3:0] LatInit = 4'(LAT);
  localparam int Depth = 1 << AW;

  stateT         state;
  stateT         stateNext;
  logic [3:0]    waitCnt;
  logic [AW-1:0] adrQ;
  logic [3:0]    selQ;
  logic          weQ;
  logic [31:0]   datQ;
  logic [31:0]   mem [Depth];

  logic          enterResp;
  logic [AW-1:0] reqAdr;
  logic [3:0]    reqSel;
  logic          reqWe;
  logic [31:0]   reqDat;
  logic [31:0]   laneMask;

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) state <= IDLE;
    else         state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE: if (dwb_stb_i) stateNext = (LatInit == 4'd0) ? RESP : WAIT;
      WAIT: begin
        if (!dwb_stb_i)            stateNext = IDLE;
        else if (waitCnt == 4'd1)  stateNext = RESP;
      end
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // With no wait states the RESP entry edge is also the capture edge, so the
  // live bus fields are used instead of the (not yet loaded) captured copy.
  always_comb begin
    busy_o    = (state != IDLE);
    enterResp = (stateNext == RESP) && (state != RESP);
    if (state == IDLE) begin
      reqAdr = dwb_adr_i;
      reqSel = dwb_sel_i;
      reqWe  = dwb_we_i;
      reqDat = dwb_dat_i;
    end else begin
      reqAdr = adrQ;
      reqSel = selQ;
      reqWe  = weQ;
      reqDat = datQ;
    end
    laneMask = {{8{reqSel[3]}}, {8{reqSel[2]}}, {8{reqSel[1]}}, {8{reqSel[0]}}};
  end

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      waitCnt <= 4'd0;
      adrQ    <= '0;
      selQ    <= 4'd0;
      weQ     <= 1'b0;
      datQ    <= 32'h0;
    end else if (state == IDLE && dwb_stb_i) begin
      waitCnt <= LatInit;
      adrQ    <= dwb_adr_i;
      selQ    <= dwb_sel_i;
      weQ     <= dwb_we_i;
      datQ    <= dwb_dat_i;
    end else if (state == WAIT) begin
      waitCnt <= waitCnt - 4'd1;
    end
  end

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      dwb_ack_o <= 1'b0;
      dwb_err_o <= 1'b0;
      dwb_dat_o <= 32'h0;
    end else begin
      dwb_ack_o <= enterResp && (reqSel != 4'h0);
      dwb_err_o <= enterResp && (reqSel == 4'h0);
      if (enterResp && !reqWe && (reqSel != 4'h0))
        dwb_dat_o <= mem[reqAdr] & laneMask;
    end
  end

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      for (int i = 0; i < Depth; i++) mem[i] <= 32'h0;
    end else if (enterResp && reqWe && (reqSel != 4'h0)) begin
      for (int l = 0; l < 4; l++)
        if (reqSel[l]) mem[reqAdr][8*l +: 8] <= reqDat[8*l +: 8];
    end
  end

endmodule

// File: tb/tb_aexm_dwb_slave.sv
// Bench for aexm_dwb_slave: three instances (LAT 1, 3, 0) driven with directed
// and random bus transactions, checked every cycle against a timeline model.
module tb_aexm_dwb_slave;

  localparam int N = 8192;

  logic        gclk = 1'b0;
  logic        grst_n;
  logic        stb [3];
  logic        we  [3];
  logic [3:0]  adr [3];
  logic [3:0]  sel [3];
  logic [31:0] dat [3];
  logic [31:0] datO [3];
  logic        ack [3];
  logic        err [3];
  logic        busy [3];

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  bit          eAck  [3][N];
  bit          eErr  [3][N];
  bit          eBusy [3][N];
  bit          eRd   [3][N];
  logic [31:0] eDat  [3][N];
  logic [31:0] mMem  [3][16];
  logic [31:0] lastDat [3];
  int          freeEdge [3];

  for (genvar g = 0; g < 3; g++) begin : gDut
    aexm_dwb_slave #(.AW(4), .LAT(g == 0 ? 1 : (g == 1 ? 3 : 0))) dut (
      .gclk      (gclk),
      .grst_n    (grst_n),
      .dwb_stb_i (stb[g]),
      .dwb_we_i  (we[g]),
      .dwb_adr_i (adr[g]),
      .dwb_sel_i (sel[g]),
      .dwb_dat_i (dat[g]),
      .dwb_dat_o (datO[g]),
      .dwb_ack_o (ack[g]),
      .dwb_err_o (err[g]),
      .busy_o    (busy[g])
    );
  end

  always #5 gclk = ~gclk;
  always @(posedge gclk) cyc <= cyc + 1;

  function automatic int latOf(int d);
    return (d == 0) ? 1 : ((d == 1) ? 3 : 0);
  endfunction

  function automatic logic [31:0] maskOf(logic [3:0] s);
    logic [31:0] m;
    m = 32'h0;
    for (int i = 0; i < 4; i++) if (s[i]) m[8*i +: 8] = 8'hFF;
    return m;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Per-cycle compare against the model timeline.
  always @(negedge gclk) begin
    if (cyc < N) begin
      for (int d = 0; d < 3; d++) begin
        chk($sformatf("ack[%0d]", d),  {31'h0, ack[d]},  {31'h0, eAck[d][cyc]});
        chk($sformatf("err[%0d]", d),  {31'h0, err[d]},  {31'h0, eErr[d][cyc]});
        chk($sformatf("busy[%0d]", d), {31'h0, busy[d]}, {31'h0, eBusy[d][cyc]});
        if (eRd[d][cyc]) lastDat[d] = eDat[d][cyc];
        chk($sformatf("dat[%0d]", d), datO[d], lastDat[d]);
      end
    end
  end

  task automatic dropAll();
    for (int d = 0; d < 3; d++) stb[d] = 1'b0;
  endtask

  task automatic idle(int n);
    dropAll();
    repeat (n) @(negedge gclk);
  endtask

  task automatic startReq(int d, bit w, logic [3:0] a, logic [3:0] s, logic [31:0] v, output int k);
    for (int o = 0; o < 3; o++) if (o != d) stb[o] = 1'b0;
    stb[d] = 1'b1;
    we[d]  = w;
    adr[d] = a;
    sel[d] = s;
    dat[d] = v;
    k = (cyc + 1 > freeEdge[d]) ? cyc + 1 : freeEdge[d];
    if (k + latOf(d) + 2 >= N) begin
      $display("FAIL cycle budget exceeded at cycle %0d", cyc);
      $fatal(1);
    end
  endtask

  // Full transaction; strobe stays high afterwards so a following call on the
  // same instance runs back-to-back.
  task automatic issue(int d, bit w, logic [3:0] a, logic [3:0] s, logic [31:0] v,
                       bit lit, logic [31:0] litDat);
    int k, l;
    l = latOf(d);
    startReq(d, w, a, s, v, k);
    for (int i = k; i <= k + l; i++) eBusy[d][i] = 1'b1;
    if (s == 4'h0) begin
      eErr[d][k+l] = 1'b1;
    end else begin
      eAck[d][k+l] = 1'b1;
      if (w) mMem[d][a] = (mMem[d][a] & ~maskOf(s)) | (v & maskOf(s));
      else begin
        eRd[d][k+l]  = 1'b1;
        eDat[d][k+l] = mMem[d][a] & maskOf(s);
      end
    end
    freeEdge[d] = k + l + 2;
    while (cyc < k + l) @(negedge gclk);
    if (lit) begin
      chk("litDat", datO[d], litDat);
      chk("litResp", {31'h0, ack[d] | err[d]}, 32'h1);
    end
  endtask

  task automatic abortTxn(int d, bit w, logic [3:0] a, logic [3:0] s, logic [31:0] v, int j);
    int k;
    startReq(d, w, a, s, v, k);
    for (int i = k; i <= k + j; i++) eBusy[d][i] = 1'b1;
    freeEdge[d] = k + j + 2;
    while (cyc < k + j) @(negedge gclk);
    stb[d] = 1'b0;
    @(negedge gclk);
    chk("abortBusy", {31'h0, busy[d]}, 32'h0);
    chk("abortAck", {31'h0, ack[d]}, 32'h0);
  endtask

  initial begin
    int k;
    bit w;
    int d;
    logic [3:0] a, s;
    logic [31:0] v;

    grst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      stb[i] = 1'b0; we[i] = 1'b0; adr[i] = 4'h0; sel[i] = 4'h0; dat[i] = 32'h0;
      lastDat[i] = 32'h0; freeEdge[i] = 0;
      for (int m = 0; m < 16; m++) mMem[i][m] = 32'h0;
    end
    repeat (2) @(negedge gclk);
    for (int i = 0; i < 3; i++) begin
      chk("rstAck", {31'h0, ack[i]}, 32'h0);
      chk("rstBusy", {31'h0, busy[i]}, 32'h0);
      chk("rstDat", datO[i], 32'h0);
    end
    grst_n = 1'b1;

    // LAT=1 write/read, byte lanes, error
    issue(0, 1, 4'd3, 4'hF, 32'hDEADBEEF, 0, 0);
    issue(0, 0, 4'd3, 4'hF, 32'h0, 1, 32'hDEADBEEF);
    issue(0, 1, 4'd5, 4'hF, 32'h11223344, 0, 0);
    issue(0, 1, 4'd5, 4'h4, 32'h00AA0000, 0, 0);
    issue(0, 0, 4'd5, 4'hF, 32'h0, 1, 32'h11AA3344);
    issue(0, 0, 4'd5, 4'h3, 32'h0, 1, 32'h00003344);
    issue(0, 1, 4'd2, 4'h0, 32'hFFFFFFFF, 1, 32'h00003344);
    chk("errPulse", {30'h0, err[0], ack[0]}, 32'h2);
    issue(0, 0, 4'd2, 4'hF, 32'h0, 1, 32'h00000000);
    idle(2);

    // LAT=3 abort one cycle after capture
    issue(1, 1, 4'd4, 4'hF, 32'h01020304, 0, 0);
    abortTxn(1, 1, 4'd4, 4'hF, 32'hFFFFFFFF, 0);
    issue(1, 0, 4'd4, 4'hF, 32'h0, 1, 32'h01020304);
    idle(1);

    // LAT=0 back-to-back
    issue(2, 1, 4'd0, 4'hF, 32'hA0A0A0A0, 0, 0);
    issue(2, 1, 4'd1, 4'hF, 32'hA1A1A1A1, 0, 0);
    issue(2, 1, 4'd2, 4'hF, 32'hA2A2A2A2, 0, 0);
    issue(2, 0, 4'd0, 4'hF, 32'h0, 1, 32'hA0A0A0A0);
    issue(2, 0, 4'd1, 4'hF, 32'h0, 1, 32'hA1A1A1A1);
    issue(2, 0, 4'd2, 4'hF, 32'h0, 1, 32'hA2A2A2A2);
    idle(2);

    // Reset during WAIT of a write to adr 7
    startReq(1, 1, 4'd7, 4'hF, 32'hCAFEF00D, k);
    eBusy[1][k] = 1'b1;
    while (cyc < k) @(negedge gclk);
    #2 grst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("midRstAck", {31'h0, ack[i]}, 32'h0);
      chk("midRstErr", {31'h0, err[i]}, 32'h0);
      chk("midRstBusy", {31'h0, busy[i]}, 32'h0);
      chk("midRstDat", datO[i], 32'h0);
      for (int c = cyc + 1; c < N; c++) begin
        eAck[i][c] = 1'b0; eErr[i][c] = 1'b0; eBusy[i][c] = 1'b0; eRd[i][c] = 1'b0;
      end
      for (int m = 0; m < 16; m++) mMem[i][m] = 32'h0;
      lastDat[i] = 32'h0;
      freeEdge[i] = 0;
    end
    dropAll();
    repeat (2) @(negedge gclk);
    grst_n = 1'b1;
    issue(1, 0, 4'd7, 4'hF, 32'h0, 1, 32'h00000000);
    issue(0, 0, 4'd3, 4'hF, 32'h0, 1, 32'h00000000);

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      d = $urandom_range(0, 2);
      w = 1'($urandom_range(0, 1));
      a = 4'($urandom_range(0, 15));
      s = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      v = $urandom;
      if (d == 1 && $urandom_range(0, 4) == 0) abortTxn(1, w, a, s, v, $urandom_range(0, 1));
      else issue(d, w, a, s, v, 0, 0);
      if ($urandom_range(0, 5) == 0) idle($urandom_range(1, 3));
    end

    idle(4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
